// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads opcode (and optional operand) words from program memory
// and issues them to the control unit. Optional build macro FETCH_TIMEOUT_EN adds a memory-wait watchdog.
module instr_fetch #(
  parameter int         word_size      = 16,
  parameter logic [7:0] HALT_OP        = 8'hFE,
  parameter int         TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [word_size-1:0] start_addr,
  output logic [word_size-1:0] mem_addr,
  output logic                 mem_rd_en,
  input  logic [word_size-1:0] mem_rdata,
  input  logic                 mem_valid,
  output logic [word_size-1:0] instruction,
  output logic [word_size-1:0] pre_data,
  output logic                 issue,
  output logic [word_size-1:0] pc,
  output logic                 busy,
  output logic                 halted,
  output logic                 fault
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ_OP   = 3'd1,
    ST_REQ_DATA = 3'd2,
    ST_ISSUE    = 3'd3,
    ST_HOLD     = 3'd4,
    ST_HALTED   = 3'd5
  } state_t;

  localparam logic [word_size-1:0] ZERO_W = {word_size{1'b0}};
  localparam logic [word_size-1:0] ONE_W  = {{(word_size-1){1'b0}}, 1'b1};

  function automatic logic has_operand(input logic [7:0] op);
    case (op)
      8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h13,
      8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F: has_operand = 1'b1;
      default:                                          has_operand = 1'b0;
    endcase
  endfunction

  state_t               state_r, state_s;
  logic [word_size-1:0] pc_r, pc_s;
  logic [word_size-1:0] instr_r, instr_s;
  logic [word_size-1:0] pre_r, pre_s;
  logic                 fault_r, fault_s;
  logic [word_size-1:0] mem_addr_r;
  logic                 mem_rd_en_r, issue_r, busy_r, halted_r;
  logic                 tmo_hit_s;

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_r;

  assign tmo_hit_s = (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));

  // Wait-cycle counter; any state change (i.e. entering a request state) restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_r <= {TW{1'b0}};
    end else if (state_s != state_r) begin
      tmo_cnt_r <= {TW{1'b0}};
    end else if ((state_r == ST_REQ_OP) || (state_r == ST_REQ_DATA)) begin
      tmo_cnt_r <= tmo_cnt_r + TW'(1);
    end else begin
      tmo_cnt_r <= {TW{1'b0}};
    end
  end
`else
  // Unbounded wait: the watchdog never fires; the parameter is kept for a uniform port/param list.
  assign tmo_hit_s = 1'b0 & (TIMEOUT_CYCLES < 0);
`endif

  // Next-state, program counter and captured-word logic.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    instr_s = instr_r;
    pre_s   = pre_r;
    fault_s = fault_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          pc_s    = start_addr;
          state_s = ST_REQ_OP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ_OP: begin
        if (mem_valid) begin
          if (mem_rdata[7:0] == HALT_OP) begin
            state_s = ST_HALTED;
          end else begin
            instr_s = mem_rdata;
            pre_s   = ZERO_W;
            pc_s    = pc_r + ONE_W;
            state_s = has_operand(mem_rdata[7:0]) ? ST_REQ_DATA : ST_ISSUE;
          end
        end else if (tmo_hit_s) begin
          fault_s = 1'b1;
          state_s = ST_HALTED;
        end else begin
          state_s = ST_REQ_OP;
        end
      end
      ST_REQ_DATA: begin
        if (mem_valid) begin
          pre_s   = mem_rdata;
          pc_s    = pc_r + ONE_W;
          state_s = ST_ISSUE;
        end else if (tmo_hit_s) begin
          fault_s = 1'b1;
          state_s = ST_HALTED;
        end else begin
          state_s = ST_REQ_DATA;
        end
      end
      ST_ISSUE:  state_s = ST_HOLD;
      ST_HOLD:   state_s = ST_REQ_OP;
      ST_HALTED: state_s = ST_HALTED;
      default:   state_s = ST_IDLE;
    endcase
  end

  // State and registered outputs, all decoded from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      pc_r        <= ZERO_W;
      instr_r     <= ZERO_W;
      pre_r       <= ZERO_W;
      fault_r     <= 1'b0;
      mem_addr_r  <= ZERO_W;
      mem_rd_en_r <= 1'b0;
      issue_r     <= 1'b0;
      busy_r      <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      instr_r     <= instr_s;
      pre_r       <= pre_s;
      fault_r     <= fault_s;
      mem_addr_r  <= pc_s;
      mem_rd_en_r <= (state_s == ST_REQ_OP) || (state_s == ST_REQ_DATA);
      issue_r     <= (state_s == ST_ISSUE);
      busy_r      <= (state_s != ST_IDLE) && (state_s != ST_HALTED);
      halted_r    <= (state_s == ST_HALTED);
    end
  end

  assign mem_addr    = mem_addr_r;
  assign mem_rd_en   = mem_rd_en_r;
  assign instruction = instr_r;
  assign pre_data    = pre_r;
  assign issue       = issue_r;
  assign pc          = pc_r;
  assign busy        = busy_r;
  assign halted      = halted_r;
  assign fault       = fault_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed programs in a behavioural memory, a forked
// monitor compares every issue pulse against queued expectations.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] start_addr, mem_addr, mem_rdata, instruction, pre_data, pc;
  logic        mem_rd_en, mem_valid, issue, busy, halted, fault;

  logic [15:0] mem [0:65535];
  int          mem_delay = 0;
  logic        mem_enable = 1'b1;
  logic        force_valid = 1'b0;
  int          wait_cnt = 0;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pre;
    logic [15:0] pc;
    int          gap;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_issue = 0;

  instr_fetch dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .instruction(instruction), .pre_data(pre_data), .issue(issue), .pc(pc),
    .busy(busy), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  // Memory model: answers after mem_delay wait cycles, or never when disabled.
  assign mem_rdata = mem[mem_addr];
  assign mem_valid = force_valid | (mem_rd_en & mem_enable & (wait_cnt >= mem_delay));

  always @(posedge clk) begin
    if (!mem_rd_en || mem_valid) wait_cnt <= 0;
    else                         wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_issue(input logic [15:0] i, input logic [15:0] p, input logic [15:0] c, input int g);
    exp_t e;
    e = '{i, p, c, g};
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (issue === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_issue: got instruction %h pc %h expected no issue", instruction, pc);
        end else begin
          e = sb.pop_front();
          check("issue_instr", {16'h0000, instruction}, {16'h0000, e.instr});
          check("issue_pre",   {16'h0000, pre_data},    {16'h0000, e.pre});
          check("issue_pc",    {16'h0000, pc},          {16'h0000, e.pc});
          if (e.gap != 0) check("issue_gap", cyc - last_issue, e.gap);
        end
        last_issue = cyc;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] addr);
    start_addr = addr;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_halt(input string name, input int budget);
    for (int i = 0; i < budget && halted !== 1'b1; i++) @(negedge clk);
    check(name, halted, 1'b1);
  endtask

  initial begin
    int rd_cnt;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h00FE;
    reset = 1'b1; start = 1'b0; start_addr = 16'h0000;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pc", pc, 16'h0000);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_rd_en", mem_rd_en, 1'b0);
    check("rst_instr", instruction, 16'h0000);
    check("rst_pre", pre_data, 16'h0000);
    check("rst_issue", issue, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_fault", fault, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Operand instructions, zero-wait: 4 cycles issue-to-issue
    mem[16'h0010] = 16'h0103; mem[16'h0011] = 16'h00AA;
    mem[16'h0012] = 16'h0219; mem[16'h0013] = 16'h1234;
    expect_issue(16'h0103, 16'h00AA, 16'h0012, 0);
    expect_issue(16'h0219, 16'h1234, 16'h0014, 4);
    do_start(16'h0010);
    wait_halt("t1_halt", 40);
    check("t1_pc", pc, 16'h0014);
    check("t1_busy", busy, 1'b0);
    check("t1_drained", sb.size(), 0);
    do_reset();

    // No-operand instructions, 3 cycles apart, then halt; start ignored while halted
    mem[16'h0000] = 16'h0010; mem[16'h0001] = 16'h0014; mem[16'h0002] = 16'h00FE;
    expect_issue(16'h0010, 16'h0000, 16'h0001, 0);
    expect_issue(16'h0014, 16'h0000, 16'h0002, 3);
    do_start(16'h0000);
    wait_halt("t2_halt", 40);
    check("t2_pc", pc, 16'h0002);
    check("t2_drained", sb.size(), 0);
    do_start(16'h0100);
    repeat (3) @(negedge clk);
    check("t2_still_halted", halted, 1'b1);
    check("t2_pc_kept", pc, 16'h0002);
    check("t2_rd_en_off", mem_rd_en, 1'b0);
    do_reset();
    check("t2_reset_exit", halted, 1'b0);

    // Slow memory: 5 wait cycles per word, read request held throughout
    mem[16'h0020] = 16'h0011; mem[16'h0021] = 16'h5555; mem[16'h0022] = 16'h00FE;
    mem_delay = 5;
    expect_issue(16'h0011, 16'h5555, 16'h0022, 0);
    do_start(16'h0020);
    rd_cnt = 0;
    for (int i = 0; i < 100 && issue !== 1'b1; i++) begin
      if (mem_rd_en) rd_cnt++;
      @(negedge clk);
    end
    check("t3_issue_seen", issue, 1'b1);
    check("t3_rd_en_cycles", rd_cnt, 12);
    @(negedge clk);
    check("t3_hold_instr", instruction, 16'h0011);
    check("t3_hold_pre", pre_data, 16'h5555);
    check("t3_hold_issue", issue, 1'b0);
    wait_halt("t3_halt", 40);
    mem_delay = 0;
    do_reset();

    // PC wrap: operand comes from address 0 after 16'hFFFF
    mem[16'hFFFF] = 16'h0203; mem[16'h0000] = 16'h0005; mem[16'h0001] = 16'h00FE;
    expect_issue(16'h0203, 16'h0005, 16'h0001, 0);
    do_start(16'hFFFF);
    wait_halt("t4_halt", 40);
    check("t4_pc", pc, 16'h0001);
    do_reset();

    // Reset in REQ_DATA with mem_valid high; late responses ignored
    do_start(16'h0010);
    @(negedge clk);
    check("t5_in_data_req", {mem_rd_en, mem_valid}, 2'b11);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_issue", issue, 1'b0);
    check("t5_instr", instruction, 16'h0000);
    check("t5_pc", pc, 16'h0000);
    check("t5_rd_en", mem_rd_en, 1'b0);
    force_valid = 1'b1;
    repeat (3) @(negedge clk);
    force_valid = 1'b0;
    check("t5_late_busy", busy, 1'b0);
    check("t5_late_pc", pc, 16'h0000);
    check("t5_late_instr", instruction, 16'h0000);

    // Memory that never answers
    mem_enable = 1'b0;
    do_start(16'h0040);
`ifdef FETCH_TIMEOUT_EN
    repeat (15) @(negedge clk);
    check("t6_not_yet_halted", halted, 1'b0);
    check("t6_still_waiting", mem_rd_en, 1'b1);
    @(negedge clk);
    check("t6_halted", halted, 1'b1);
    check("t6_fault", fault, 1'b1);
    check("t6_rd_en_off", mem_rd_en, 1'b0);
`else
    repeat (20) @(negedge clk);
    check("t6_rd_en_held", mem_rd_en, 1'b1);
    check("t6_no_fault", fault, 1'b0);
    check("t6_not_halted", halted, 1'b0);
`endif
    mem_enable = 1'b1;
    do_reset();
    check("t6_fault_cleared", fault, 1'b0);

    repeat (3) @(negedge clk);
    check("final_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
